// File: rtl/qq_pkg.sv
// rtl/qq_pkg.sv - shared defaults, entry/state types and heap index helpers for quickq
package qq_pkg;

  localparam int QQ_KW    = 32;
  localparam int QQ_VW    = 32;
  localparam int QQ_DEPTH = 8;

  typedef struct packed {
    logic [QQ_KW-1:0] key;
    logic [QQ_VW-1:0] val;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SIFT_UP,
    ST_SIFT_DOWN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_ENQ,
    OP_DEQ,
    OP_REPL
  } op_t;

  // Heap is 1-based: parent of i is i/2, children are 2i and 2i+1.
  function automatic int unsigned qq_parent(input int unsigned idx);
    return idx >> 1;
  endfunction

  function automatic int unsigned qq_left(input int unsigned idx);
    return idx << 1;
  endfunction

  function automatic int unsigned qq_right(input int unsigned idx);
    return (idx << 1) + 1;
  endfunction

endpackage

// File: rtl/qq_min_child.sv
// rtl/qq_min_child.sv - picks the smaller of two sibling heap entries (left wins ties)
module qq_min_child
  import qq_pkg::*;
#(
  parameter type T = entry_t
) (
  input  T     left_i,
  input  T     right_i,
  input  logic right_vld_i,
  output T     min_o,
  output logic sel_right_o
);

  // Right child only wins when it exists and is strictly smaller
  always_comb begin
    sel_right_o = right_vld_i && (right_i.key < left_i.key);
    min_o       = sel_right_o ? right_i : left_i;
  end

endmodule

// File: rtl/quickq_top.sv
// rtl/quickq_top.sv - register min-heap priority queue; replace-head op built only with QQ_REPL_EN
module quickq_top
  import qq_pkg::*;
#(
  parameter int KW    = QQ_KW,
  parameter int VW    = QQ_VW,
  parameter int DEPTH = QQ_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  logic          deq,
  input  logic          repl,
  input  logic [KW-1:0] lt_i,
  input  logic [VW-1:0] rt_i,
  output logic [KW-1:0] lt_o,
  output logic [VW-1:0] rt_o,
  output logic          enq_o,
  output logic          deq_o,
  output logic          repl_o,
  output logic          full_t,
  output logic          empty_t,
  output logic          rdy_t
);

  localparam int AW  = $clog2(DEPTH) + 1;
  localparam int AW1 = AW + 1;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [VW-1:0] val;
  } ent_t;

  ent_t          heap_q [1:DEPTH];
  state_t        state_q;
  op_t           op_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] idx_q;
  logic [KW-1:0] lt_q;
  logic [VW-1:0] rt_q;
  logic          enq_q, deq_q, full_q, empty_q, rdy_q;

  ent_t          new_ent, node, par_ent, ent_l, ent_r, mc_ent;
  logic [AW-1:0] par_idx, child_idx;
  logic [AW:0]   l_idx, r_idx;
  logic          has_l, has_r, mc_right, child_has_l;

  assign new_ent = {lt_i, rt_i};

  // Neighbourhood of the current sift position; out-of-range slots read as zero
  always_comb begin
    par_idx     = AW'(qq_parent(32'(idx_q)));
    l_idx       = AW1'(qq_left(32'(idx_q)));
    r_idx       = AW1'(qq_right(32'(idx_q)));
    has_l       = l_idx <= {1'b0, cnt_q};
    has_r       = r_idx <= {1'b0, cnt_q};
    node        = heap_q[idx_q];
    par_ent     = (idx_q > AW'(1)) ? heap_q[par_idx] : '0;
    ent_l       = has_l ? heap_q[l_idx[AW-1:0]] : '0;
    ent_r       = has_r ? heap_q[r_idx[AW-1:0]] : '0;
    child_idx   = mc_right ? r_idx[AW-1:0] : l_idx[AW-1:0];
    child_has_l = {child_idx, 1'b0} <= {1'b0, cnt_q};
  end

  qq_min_child #(.T(ent_t)) u_min_child (
    .left_i      (ent_l),
    .right_i     (ent_r),
    .right_vld_i (has_r),
    .min_o       (mc_ent),
    .sel_right_o (mc_right)
  );

`ifdef QQ_REPL_EN
  logic repl_q;
  assign repl_o = repl_q;
`else
  logic unused_repl;
  assign unused_repl = repl;
  assign repl_o      = 1'b0;
`endif

  // Command acceptance, one sift level per cycle, then publish head/flags and strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ENQ;
      cnt_q   <= '0;
      idx_q   <= AW'(1);
      for (int i = 1; i <= DEPTH; i++) heap_q[i] <= '0;
      lt_q    <= '0;
      rt_q    <= '0;
      enq_q   <= 1'b0;
      deq_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      rdy_q   <= 1'b1;
`ifdef QQ_REPL_EN
      repl_q  <= 1'b0;
`endif
    end else begin
      enq_q <= 1'b0;
      deq_q <= 1'b0;
`ifdef QQ_REPL_EN
      repl_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (deq) begin
            if (cnt_q != '0) begin
              heap_q[1] <= heap_q[cnt_q];
              cnt_q     <= cnt_q - AW'(1);
              idx_q     <= AW'(1);
              op_q      <= OP_DEQ;
              rdy_q     <= 1'b0;
              state_q   <= (cnt_q == AW'(1)) ? ST_DONE : ST_SIFT_DOWN;
            end
          end
`ifdef QQ_REPL_EN
          else if (repl) begin
            if (cnt_q != '0) begin
              heap_q[1] <= new_ent;
              idx_q     <= AW'(1);
              op_q      <= OP_REPL;
              rdy_q     <= 1'b0;
              state_q   <= ST_SIFT_DOWN;
            end
          end
`endif
          else if (enq) begin
            if (cnt_q != AW'(DEPTH)) begin
              heap_q[cnt_q + AW'(1)] <= new_ent;
              cnt_q   <= cnt_q + AW'(1);
              idx_q   <= cnt_q + AW'(1);
              op_q    <= OP_ENQ;
              rdy_q   <= 1'b0;
              state_q <= (cnt_q == '0) ? ST_DONE : ST_SIFT_UP;
            end
          end
        end
        ST_SIFT_UP: begin
          if (idx_q > AW'(1) && node.key < par_ent.key) begin
            heap_q[idx_q]   <= par_ent;
            heap_q[par_idx] <= node;
            idx_q           <= par_idx;
            if (par_idx == AW'(1)) state_q <= ST_DONE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_SIFT_DOWN: begin
          if (has_l && mc_ent.key < node.key) begin
            heap_q[idx_q]     <= mc_ent;
            heap_q[child_idx] <= node;
            idx_q             <= child_idx;
            if (!child_has_l) state_q <= ST_DONE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          lt_q    <= (cnt_q == '0) ? '0 : heap_q[1].key;
          rt_q    <= (cnt_q == '0) ? '0 : heap_q[1].val;
          full_q  <= (cnt_q == AW'(DEPTH));
          empty_q <= (cnt_q == '0);
          rdy_q   <= 1'b1;
          state_q <= ST_IDLE;
          case (op_q)
            OP_ENQ:  enq_q <= 1'b1;
            OP_DEQ:  deq_q <= 1'b1;
            default: begin
`ifdef QQ_REPL_EN
              repl_q <= 1'b1;
`endif
            end
          endcase
        end
      endcase
    end
  end

  assign lt_o    = lt_q;
  assign rt_o    = rt_q;
  assign enq_o   = enq_q;
  assign deq_o   = deq_q;
  assign full_t  = full_q;
  assign empty_t = empty_q;
  assign rdy_t   = rdy_q;

endmodule

// File: tb/tb_quickq_top.sv
// tb/tb_quickq_top.sv - scoreboard bench for quickq_top; expectations follow QQ_REPL_EN
module tb_quickq_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enq = 1'b0, deq = 1'b0, repl = 1'b0;
  logic [31:0] lt_i = '0, rt_i = '0;
  logic [31:0] lt_o, rt_o;
  logic        enq_o, deq_o, repl_o, full_t, empty_t, rdy_t;

  int checks = 0;
  int failures = 0;
  int nstrobe = 0, nenq = 0, ndeq = 0, nrepl = 0;

`ifdef QQ_REPL_EN
  localparam bit REPL_ON = 1'b1;
`else
  localparam bit REPL_ON = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] k;
    logic [31:0] v;
    logic        full;
    logic        empty;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb_e;
  logic [31:0] mk[$];
  logic [31:0] mv[$];

  quickq_top dut (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .repl(repl),
    .lt_i(lt_i), .rt_i(rt_i), .lt_o(lt_o), .rt_o(rt_o),
    .enq_o(enq_o), .deq_o(deq_o), .repl_o(repl_o),
    .full_t(full_t), .empty_t(empty_t), .rdy_t(rdy_t)
  );

  always #5 clk = ~clk;

  function automatic int min_pos();
    int p = 0;
    for (int i = 1; i < mk.size(); i++) if (mk[i] < mk[p]) p = i;
    return p;
  endfunction

  // Reference: unordered list of live entries, minimum found by linear scan
  task automatic model_cmd(input bit e, input bit d, input bit r, input logic [31:0] k, input logic [31:0] v);
    int   m;
    bit   go = 1'b0;
    exp_t x;
    if (d) begin
      if (mk.size() != 0) begin
        m = min_pos(); mk.delete(m); mv.delete(m); go = 1'b1; x.op = 3'b010;
      end
    end else if (r && REPL_ON) begin
      if (mk.size() != 0) begin
        m = min_pos(); mk.delete(m); mv.delete(m);
        mk.push_back(k); mv.push_back(v); go = 1'b1; x.op = 3'b001;
      end
    end else if (e) begin
      if (mk.size() < 8) begin
        mk.push_back(k); mv.push_back(v); go = 1'b1; x.op = 3'b100;
      end
    end
    if (go) begin
      m       = min_pos();
      x.k     = (mk.size() == 0) ? 32'd0 : mk[m];
      x.v     = (mk.size() == 0) ? 32'd0 : mv[m];
      x.full  = (mk.size() == 8);
      x.empty = (mk.size() == 0);
      sb.push_back(x);
    end
  endtask

  task automatic send(input bit e, input bit d, input bit r, input logic [31:0] k);
    @(posedge clk); #1;
    enq = e; deq = d; repl = r; lt_i = k; rt_i = k * 16 + 1;
    model_cmd(e, d, r, k, k * 16 + 1);
    @(posedge clk); #1;
    enq = 1'b0; deq = 1'b0; repl = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Every completion strobe is matched against the oldest scoreboard entry
  always @(negedge clk) begin
    if (rst && (enq_o || deq_o || repl_o)) begin
      nstrobe++;
      if (enq_o) nenq++;
      if (deq_o) ndeq++;
      if (repl_o) nrepl++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe got op=%b req=none", {enq_o, deq_o, repl_o});
      end else begin
        sb_e = sb.pop_front();
        if ({enq_o, deq_o, repl_o} !== sb_e.op || lt_o !== sb_e.k || rt_o !== sb_e.v ||
            full_t !== sb_e.full || empty_t !== sb_e.empty) begin
          failures++;
          $display("FAIL strobe_result got op=%b key=%0d val=%0d full=%b empty=%b req op=%b key=%0d val=%0d full=%b empty=%b",
                   {enq_o, deq_o, repl_o}, lt_o, rt_o, full_t, empty_t, sb_e.op, sb_e.k, sb_e.v, sb_e.full, sb_e.empty);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({empty_t, full_t, rdy_t} !== 3'b101) begin
      failures++; $display("FAIL reset_flags got=%b req=101", {empty_t, full_t, rdy_t});
    end
    checks++;
    if (lt_o !== 32'd0 || rt_o !== 32'd0) begin
      failures++; $display("FAIL reset_head got=%0d/%0d req=0/0", lt_o, rt_o);
    end
    checks++;
    if ({enq_o, deq_o, repl_o} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes got=%b req=000", {enq_o, deq_o, repl_o});
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_enqueue();
    logic [31:0] keys[8]  = '{5, 10, 3, 20, 2, 12, 27, 8};
    logic [31:0] heads[8] = '{5, 5, 3, 3, 2, 2, 2, 2};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rdy_t !== 1'b1) begin failures++; $display("FAIL enq_rdy got=%b req=1", rdy_t); end
      send(1'b1, 1'b0, 1'b0, keys[i]);
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL enq_timeout got pending=%0d req=0", sb.size()); end
      checks++;
      if (lt_o !== heads[i]) begin failures++; $display("FAIL enq_head got=%0d req=%0d", lt_o, heads[i]); end
    end
    checks++;
    if (full_t !== 1'b1) begin failures++; $display("FAIL enq_full got=%b req=1", full_t); end
    checks++;
    if (nenq != 8) begin failures++; $display("FAIL enq_count got=%0d req=8", nenq); end
  endtask

  task automatic test_replace();
    logic [31:0] h1 = REPL_ON ? 32'd3 : 32'd2;
    logic [31:0] h2 = REPL_ON ? 32'd4 : 32'd2;
    int          n0 = nrepl;
    int          nr = REPL_ON ? 2 : 0;
    send(1'b0, 1'b0, 1'b1, 32'd9);
    checks++;
    if (lt_o !== h1) begin failures++; $display("FAIL repl9_head got=%0d req=%0d", lt_o, h1); end
    send(1'b0, 1'b0, 1'b1, 32'd4);
    checks++;
    if (lt_o !== h2 || full_t !== 1'b1) begin
      failures++; $display("FAIL repl4_head got=%0d full=%b req=%0d full=1", lt_o, full_t, h2);
    end
    checks++;
    if (nrepl - n0 != nr) begin failures++; $display("FAIL repl_count got=%0d req=%0d", nrepl - n0, nr); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL repl_timeout got pending=%0d req=0", sb.size()); end
  endtask

  task automatic test_full_enq();
    logic [31:0] h  = REPL_ON ? 32'd4 : 32'd2;
    int          ns = nstrobe;
    send(1'b1, 1'b0, 1'b0, 32'd1);
    checks++;
    if (nstrobe != ns) begin failures++; $display("FAIL full_enq_strobe got=%0d req=%0d", nstrobe, ns); end
    checks++;
    if (lt_o !== h || full_t !== 1'b1 || rdy_t !== 1'b1) begin
      failures++; $display("FAIL full_enq_state got=%0d full=%b rdy=%b req=%0d full=1 rdy=1", lt_o, full_t, rdy_t, h);
    end
  endtask

  task automatic test_drain();
    logic [31:0] ha[8] = '{4, 5, 8, 9, 10, 12, 20, 27};
    logic [31:0] hb[8] = '{2, 3, 5, 8, 10, 12, 20, 27};
    int          ns;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lt_o !== (REPL_ON ? ha[i] : hb[i])) begin
        failures++; $display("FAIL drain_head got=%0d req=%0d", lt_o, REPL_ON ? ha[i] : hb[i]);
      end
      send(1'b0, 1'b1, 1'b0, 32'd0);
    end
    checks++;
    if (empty_t !== 1'b1 || lt_o !== 32'd0 || full_t !== 1'b0) begin
      failures++; $display("FAIL drain_empty got empty=%b head=%0d full=%b req empty=1 head=0 full=0", empty_t, lt_o, full_t);
    end
    ns = nstrobe;
    send(1'b0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (nstrobe != ns || empty_t !== 1'b1) begin
      failures++; $display("FAIL drain_extra got strobes=%0d empty=%b req strobes=%0d empty=1", nstrobe, empty_t, ns);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL drain_timeout got pending=%0d req=0", sb.size()); end
  endtask

  task automatic test_simultaneous();
    int ne, nd;
    send(1'b1, 1'b0, 1'b0, 32'd7);
    send(1'b1, 1'b0, 1'b0, 32'd6);
    ne = nenq; nd = ndeq;
    send(1'b1, 1'b1, 1'b0, 32'd1);
    checks++;
    if (ndeq - nd != 1 || nenq != ne) begin
      failures++; $display("FAIL simul_strobes got deq=%0d enq=%0d req deq=1 enq=0", ndeq - nd, nenq - ne);
    end
    checks++;
    if (lt_o !== 32'd7 || rt_o !== 32'd113) begin
      failures++; $display("FAIL simul_head got=%0d/%0d req=7/113", lt_o, rt_o);
    end
    send(1'b0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (empty_t !== 1'b1 || sb.size() != 0) begin
      failures++; $display("FAIL simul_empty got empty=%b pending=%0d req empty=1 pending=0", empty_t, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int ns;
    send(1'b1, 1'b0, 1'b0, 32'd30);
    send(1'b1, 1'b0, 1'b0, 32'd20);
    send(1'b1, 1'b0, 1'b0, 32'd10);
    @(posedge clk); #1;
    enq = 1'b1; lt_i = 32'd5; rt_i = 32'd81;
    @(posedge clk); #1;
    enq = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy_t !== 1'b0) begin failures++; $display("FAIL midsift_busy got rdy=%b req=0", rdy_t); end
    rst = 1'b0;
    mk.delete(); mv.delete(); sb.delete();
    ns = nstrobe;
    #1;
    checks++;
    if ({empty_t, full_t, rdy_t} !== 3'b101 || lt_o !== 32'd0 || rt_o !== 32'd0) begin
      failures++; $display("FAIL midsift_reset got flags=%b head=%0d/%0d req flags=101 head=0/0", {empty_t, full_t, rdy_t}, lt_o, rt_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (nstrobe != ns) begin failures++; $display("FAIL midsift_strobe got=%0d req=%0d", nstrobe, ns); end
    send(1'b1, 1'b0, 1'b0, 32'd50);
    checks++;
    if (lt_o !== 32'd50 || empty_t !== 1'b0 || sb.size() != 0) begin
      failures++; $display("FAIL post_reset_enq got head=%0d empty=%b pending=%0d req head=50 empty=0 pending=0", lt_o, empty_t, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_enqueue();
    test_replace();
    test_full_enq();
    test_drain();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quickq_top.md
# quickq_top

Hardware min-priority queue ("QuickQ") holding up to DEPTH key/value entries as a binary min-heap in registers. It accepts enqueue, dequeue and replace-head commands through a ready/strobe handshake and continuously presents the smallest-key entry. It sits between a scheduler front-end and consumers that need the current minimum.

## Interface
- KW, 32, key width (lt_*)
- VW, 32, value width (rt_*)
- DEPTH, 8, maximum entries; must be a power of two
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- enq  in  1  enqueue request; entry {lt_i, rt_i}
- deq  in  1  dequeue request; removes the head
- repl  in  1  replace request; head replaced by {lt_i, rt_i}
- lt_i  in  KW  key of the new entry
- rt_i  in  VW  value of the new entry
- lt_o  out  KW  key of the head (minimum); 0 when empty
- rt_o  out  VW  value of the head; 0 when empty
- enq_o / deq_o / repl_o  out  1 each  one-cycle completion strobe for the respective operation
- full_t  out  1  count == DEPTH
- empty_t  out  1  count == 0
- rdy_t  out  1  idle; a command is accepted this cycle

## Operation
- Storage is a heap array at indices 1..DEPTH plus a count register. Keys are compared unsigned with strict less-than, so equal keys never swap.
- A command is accepted on a rising edge with rdy_t=1.
- If several commands are high, priority is deq > repl > enq. Lower-priority commands are dropped, not queued.
- Commands with rdy_t=0 are ignored.
- Illegal commands are ignored: no state change, no strobe, rdy_t stays 1. These are enq when full, and deq or repl when empty.
- ENQ: write the entry at index count+1 and increment count, then SIFT_UP.
- DEQ: move entry[count] to the root and decrement count, then SIFT_DOWN. Deq at count 1 finishes directly.
- REPL: overwrite the root with the new entry, then SIFT_DOWN. Count is unchanged.
- FSM states: IDLE, SIFT_UP, SIFT_DOWN, DONE.
- SIFT_UP: each cycle, compare the node with its parent. Swap and move up if the node is smaller; otherwise, or at the root, go to DONE.
- SIFT_DOWN: each cycle, select the smaller valid child (left child wins ties). Swap if that child is smaller than the node; otherwise, or with no children, go to DONE.
- DONE: pulse the matching strobe, update lt_o, rt_o, full_t and empty_t, return to IDLE.

## Timing
- Reset values: lt_o=0, rt_o=0, all strobes 0, full_t=0, empty_t=1, rdy_t=1, count=0.
- Accept at edge T: rdy_t drops after T.
- Each sift level takes one cycle, so a sift runs at most log2(DEPTH)=3 cycles.
- Strobe and flag updates occur in the DONE cycle. rdy_t returns to 1 on the edge that leaves DONE.
- Worst-case latency from accept to strobe is 5 cycles for DEPTH=8. Commands spaced 6 cycles apart are always accepted.
- lt_o, rt_o, full_t and empty_t are registered and stable whenever rdy_t=1.
- Reset asserted mid-operation aborts it immediately: heap is emptied and all outputs return to reset values.

## Configuration
- QQ_REPL_EN defined: the replace operation is compiled in as specified above.
- QQ_REPL_EN undefined: the repl input is ignored, repl_o is tied 0, and the replace datapath is removed.

## Structure
- Package qq_pkg holds:
  - KW, VW and DEPTH defaults
  - entry_t, a packed struct {key, val}
  - state_t, an enum of the FSM states
  - parent and child index helper functions
- Sub-module qq_min_child: combinational; takes two entries plus a right-child-valid flag and returns the smaller entry with its index.

## Test plan
- Reset: rst=0 then 1 → empty_t=1, full_t=0, rdy_t=1, lt_o=0.
- Enqueue 5,10,3,20,2,12,27,8 spaced 6 cycles → lt_o after each strobe is 5,5,3,3,2,2,2,2; full_t=1 after the 8th; enq_o pulses exactly 8 times.
- Then repl 9 → repl_o pulses, lt_o=3; then repl 4 → lt_o=4, full_t stays 1.
- Enq 1 while full → ignored: no strobe, lt_o stays 4.
- Eight deqs → heads before each are 4,5,8,9,10,12,20,27; empty_t=1 after the last; a ninth deq is ignored.
- Simultaneous enq+deq with count 2 → only deq executes. Reset asserted mid-sift → queue empty, no strobe.
